wave_pwm: RTL and testbench
===========================

# wave_pwm

Downstream output stage for the sawtooth/ramp generator: consumes its 24-bit sample word and drives a single-bit PWM pin (speaker/LED) with a gated attack/sustain/release volume envelope. A free-running PWM counter defines the output period. The block latches the generator's sample once per period, scales it by the current envelope and volume, and produces a registered duty-cycle output plus a per-period sample strobe.

## Interface
- IN_W, 24, width of incoming sample word
- PWM_W, 10, PWM counter width; period = 2^PWM_W clocks
- ENV_DIV, 4, PWM periods per envelope step (≥1)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- in  input  IN_W  sample from ramp generator, treated as unsigned
- enable  input  1  note gate; high = sound, low = release
- vol  input  3  volume ceiling, 0..7
- pwm_out  output  1  registered PWM output
- sample_tick  output  1  one-cycle pulse, first cycle of each PWM period
- busy  output  1  high whenever envelope state ≠ IDLE

## Operation
- cnt: PWM_W-bit free-running up-counter, wraps 2^PWM_W−1 → 0.
- Boundary: the rising edge at which cnt == 2^PWM_W−1. Only at boundaries are in, enable and vol sampled, duty updated and envelope advanced.
- At boundary: duty_r ← (in[IN_W−1 -: PWM_W] × eff) >> 3, where eff = min(env, vol) using pre-update env. Product width PWM_W+3; result fits PWM_W bits (max (2^PWM_W−1)·7/8).
- Every clock: pwm_out ← (cnt < duty_r), using current register values.
- env: 3-bit level 0..7; div_cnt: period counter 0..ENV_DIV−1, cleared on every state change.
- States, evaluated at boundaries only:
  - IDLE: env=0. enable=1 → ATTACK.
  - ATTACK: enable=0 → RELEASE. Otherwise div_cnt++; on div_cnt==ENV_DIV−1 wrap, env++. env reaching 7 → SUSTAIN.
  - SUSTAIN: env=7 held. enable=0 → RELEASE.
  - RELEASE: enable=1 → ATTACK (continue from current env). Otherwise step env−1 every ENV_DIV periods; env reaching 0 → IDLE.
- vol changes take effect at the next boundary via eff; env itself is independent of vol.
- sample_tick ← 1 for the single cycle in which cnt == 0, else 0.
- busy = (state ≠ IDLE), registered with state.

## Timing
- Reset (async assert, sync release on next edge): cnt=0, duty_r=0, env=0, div_cnt=0, state=IDLE, pwm_out=0, sample_tick=0, busy=0.
- First sample_tick at cnt==0 after 2^PWM_W clocks from reset release (not in the initial cnt==0 cycle).
- in → duty latency: sampled at boundary edge; pwm_out reflects new duty from the clock after cnt==0 (one-cycle register lag on pwm_out).
- duty_r=0 → pwm_out constantly 0; duty_r never equals 2^PWM_W, so pwm_out always has ≥1 low cycle per period.
- IDLE→ATTACK: env still 0 in that boundary's duty calculation; first non-zero duty appears ENV_DIV+1 boundaries after enable seen.
- Full attack: 7·ENV_DIV periods; full release: 7·ENV_DIV periods.
- enable toggles between boundaries are ignored; pulses shorter than one period can be missed.
- Reset mid-note: immediate return to IDLE, pwm_out=0.

## Test plan
- Reset held low 50 clocks with enable=1, in=FFFFFF → pwm_out, sample_tick, busy all 0; after release, first sample_tick exactly 1024 clocks later.
- PWM_W=4, ENV_DIV=1, in=FFFFFF, vol=7, enable=1 → busy high after first boundary; env ramps 7 periods; in SUSTAIN duty=(15·7)>>3=13, pwm_out high 13 of 16 cycles each period.
- Same setup, vol=3 in SUSTAIN → duty=(15·3)>>3=5; vol=0 → pwm_out stays 0 while busy=1.
- In SUSTAIN drop enable → RELEASE; duty steps down per period 13,11,9,7,5,3,1 then 0; busy falls when env hits 0.
- Release interrupted: enable re-asserted when env=4 → ATTACK from 4, reaches SUSTAIN after 3 more steps, no drop to 0.
- in=800000 (top bits 512), PWM_W=10, vol=7, SUSTAIN → duty=448; pwm_out high cycles 1..448 after cnt==0 (one-cycle lag), low otherwise.

Source files
------------

// File: rtl/wave_pwm_if.sv
// Sample/control inputs from the ramp generator and PWM pin outputs of wave_pwm.
interface wave_pwm_if #(
  parameter int IN_W = 24
);
  logic [IN_W-1:0] in;
  logic            enable;
  logic [2:0]      vol;
  logic            pwm_out;
  logic            sample_tick;
  logic            busy;

  modport master (output in, enable, vol, input pwm_out, sample_tick, busy);
  modport slave  (input in, enable, vol, output pwm_out, sample_tick, busy);
endinterface

// File: rtl/wave_pwm.sv
// PWM output stage with gated attack/sustain/release envelope; inputs sampled once per 2^PWM_W-clock period,
// pwm_out lags duty by one register stage; no backpressure, free-running.
module wave_pwm #(
  parameter int IN_W    = 24,
  parameter int PWM_W   = 10,
  parameter int ENV_DIV = 4
) (
  input logic       clk,
  input logic       reset,
  wave_pwm_if.slave bus
);
  localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_r;
  logic [PWM_W-1:0] duty_nxt;
  logic [PWM_W+2:0] prod;
  logic [2:0]       env;
  logic [2:0]       env_nxt;
  logic [2:0]       eff;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             boundary;
  logic             step;
  logic             pwm_r;
  logic             tick_r;
  logic             busy_r;
  logic             unused_bits;

  assign boundary = (cnt == {PWM_W{1'b1}});
  assign step     = (div_cnt == DIV_LAST);

  // Scale uses the envelope level from before this boundary's update.
  assign eff      = (env < bus.vol) ? env : bus.vol;
  assign prod     = (PWM_W+3)'(bus.in[IN_W-1 -: PWM_W]) * (PWM_W+3)'(eff);
  assign duty_nxt = prod[PWM_W+2:3];

  // Low sample bits and the discarded product fraction are intentionally dropped.
  assign unused_bits = ^{prod[2:0], bus.in};

  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    div_nxt   = div_cnt;
    case (state)
      ST_IDLE: begin
        env_nxt = 3'd0;
        if (bus.enable) begin
          state_nxt = ST_ATTACK;
          div_nxt   = '0;
        end
      end
      ST_ATTACK: begin
        if (!bus.enable) begin
          state_nxt = ST_RELEASE;
          div_nxt   = '0;
        end else if (env == 3'd7) begin
          // Re-attack from a full level goes straight back to sustain.
          state_nxt = ST_SUSTAIN;
          div_nxt   = '0;
        end else if (step) begin
          div_nxt = '0;
          env_nxt = env + 3'd1;
          if (env == 3'd6) state_nxt = ST_SUSTAIN;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_SUSTAIN: begin
        env_nxt = 3'd7;
        if (!bus.enable) begin
          state_nxt = ST_RELEASE;
          div_nxt   = '0;
        end
      end
      default: begin
        if (bus.enable) begin
          state_nxt = ST_ATTACK;
          div_nxt   = '0;
        end else if (env == 3'd0) begin
          // Released before the first attack step: nothing left to fade.
          state_nxt = ST_IDLE;
          div_nxt   = '0;
        end else if (step) begin
          div_nxt = '0;
          env_nxt = env - 3'd1;
          if (env == 3'd1) state_nxt = ST_IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      duty_r  <= '0;
      env     <= 3'd0;
      div_cnt <= '0;
      state   <= ST_IDLE;
      pwm_r   <= 1'b0;
      tick_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      pwm_r  <= (cnt < duty_r);
      // Registered from the wrap edge, so it is high exactly while cnt == 0.
      tick_r <= boundary;
      if (boundary) begin
        duty_r  <= duty_nxt;
        env     <= env_nxt;
        div_cnt <= div_nxt;
        state   <= state_nxt;
        busy_r  <= (state_nxt != ST_IDLE);
      end
    end
  end

  assign bus.pwm_out     = pwm_r;
  assign bus.sample_tick = tick_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_wave_pwm.sv
// Directed bench for wave_pwm: a small (PWM_W=4, ENV_DIV=1) and a full-size (PWM_W=10, ENV_DIV=4) instance.
module tb_wave_pwm;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wave_pwm_if #(.IN_W(24)) if_s ();
  wave_pwm_if #(.IN_W(24)) if_l ();

  wave_pwm #(.IN_W(24), .PWM_W(4), .ENV_DIV(1)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (if_s)
  );

  wave_pwm #(.IN_W(24), .PWM_W(10), .ENV_DIV(4)) dut_l (
    .clk  (clk),
    .reset(reset),
    .bus  (if_l)
  );

  typedef struct {
    int en;
    int vol;
    int exp_hi;
    int exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int en, input int vol, input int hi, input int bz);
    vec_t v;
    v.en = en; v.vol = vol; v.exp_hi = hi; v.exp_busy = bz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Starts on the negedge where cnt == 0 and ends on the next such negedge.
  task automatic run_period(input bit big, output int highs, output int first_hi,
                            output int last_hi, output int busy_s, output int tick_s);
    int len = big ? 1024 : 16;
    highs    = 0;
    first_hi = -1;
    last_hi  = -1;
    busy_s   = big ? int'(if_l.busy) : int'(if_s.busy);
    tick_s   = big ? int'(if_l.sample_tick) : int'(if_s.sample_tick);
    for (int j = 0; j < len; j++) begin
      if (big ? if_l.pwm_out : if_s.pwm_out) begin
        highs++;
        if (first_hi < 0) first_hi = j;
        last_hi = j;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, fh, lh, b, t;
    int bad;
    int first_s, first_l;

    add(1,7,0,0);  add(1,7,0,1);  add(1,7,0,1);  add(1,7,1,1);  add(1,7,3,1);
    add(1,7,5,1);  add(1,7,7,1);  add(1,7,9,1);  add(1,7,11,1); add(1,3,13,1);
    add(1,0,5,1);  add(1,7,0,1);  add(0,7,13,1); add(0,7,13,1); add(0,7,13,1);
    add(0,7,11,1); add(0,7,9,1);  add(0,7,7,1);  add(0,7,5,1);  add(0,7,3,1);
    add(0,7,1,0);  add(1,7,0,0);  add(1,7,0,1);  add(1,7,0,1);  add(1,7,1,1);
    add(1,7,3,1);  add(1,7,5,1);  add(1,7,7,1);  add(1,7,9,1);  add(0,7,11,1);
    add(0,7,13,1); add(0,7,13,1); add(0,7,11,1); add(1,7,9,1);  add(1,7,7,1);
    add(1,7,7,1);  add(1,7,9,1);  add(1,7,11,1); add(1,7,13,1); add(1,7,13,1);

    if_s.in = 24'hFFFFFF; if_s.enable = 1'b0; if_s.vol = 3'd7;
    if_l.in = 24'hFFFFFF; if_l.enable = 1'b1; if_l.vol = 3'd7;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held with an active gate and full-scale input.
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (if_s.pwm_out || if_s.sample_tick || if_s.busy ||
          if_l.pwm_out || if_l.sample_tick || if_l.busy) bad++;
    end
    chk("reset_hold_active_cycles", 0, bad, 0);
    chk("reset_pwm_l", 0, int'(if_l.pwm_out), 0);
    chk("reset_tick_l", 0, int'(if_l.sample_tick), 0);
    chk("reset_busy_l", 0, int'(if_l.busy), 0);

    reset   = 1'b1;
    first_s = -1;
    first_l = -1;
    for (int k = 1; k <= 2000 && first_l < 0; k++) begin
      @(negedge clk);
      if (if_s.sample_tick && first_s < 0) first_s = k;
      if (if_l.sample_tick) first_l = k;
    end
    chk("first_tick_small", 0, first_s, 16);
    chk("first_tick_large", 0, first_l, 1024);

    // Large instance: enable seen at the first boundary, ENV_DIV=4.
    for (int p = 1; p <= 30; p++) begin
      if (p == 7) if_l.in = 24'h800000;
      run_period(1'b1, hi, fh, lh, b, t);
      if (p == 1) chk("l_busy_after_first_boundary", p, b, 1);
      if (p <= 5) chk("l_zero_duty", p, hi, 0);
      if (p == 6) chk("l_first_nonzero_duty", p, hi, 127);
      if (p == 29) chk("l_duty_env6", p, hi, 384);
      if (p == 30) begin
        chk("l_duty_sustain", p, hi, 448);
        chk("l_first_high_pos", p, fh, 1);
        chk("l_last_high_pos", p, lh, 448);
        chk("l_tick_at_period_start", p, t, 1);
      end
    end

    // Small instance: attack, vol changes, full release, re-attack, interrupted release.
    for (int i = 0; i < tbl.size(); i++) begin
      if_s.enable = tbl[i].en[0];
      if_s.vol    = tbl[i].vol[2:0];
      run_period(1'b0, hi, fh, lh, b, t);
      chk("s_duty", i, hi, tbl[i].exp_hi);
      chk("s_busy", i, b, tbl[i].exp_busy);
      chk("s_tick", i, t, 1);
    end

    // Reset mid-note while pwm_out is high.
    repeat (3) @(negedge clk);
    chk("pre_reset_pwm_s", 0, int'(if_s.pwm_out), 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_pwm_s", 0, int'(if_s.pwm_out), 0);
    chk("mid_reset_busy_s", 0, int'(if_s.busy), 0);
    chk("mid_reset_busy_l", 0, int'(if_l.busy), 0);
    chk("mid_reset_pwm_l", 0, int'(if_l.pwm_out), 0);
    @(negedge clk);
    if_s.enable = 1'b0;
    if_l.enable = 1'b0;
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (if_s.pwm_out || if_s.busy) bad++;
    end
    chk("post_reset_quiet_cycles", 0, bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
